// File: rtl/valid_rr_pkg.sv
// Shared definitions for the valid-only round-robin arbiter: default sizes,
// the requester id type and the rotating-priority pick function.
package valid_rr_pkg;

  localparam int DW_DEF   = 32;
  localparam int NREQ_DEF = 3;
  localparam int IW_DEF   = $clog2(NREQ_DEF);
  localparam int MAX_NREQ = 16;
  localparam int PIW      = $clog2(MAX_NREQ);

  typedef logic [IW_DEF-1:0] id_t;

  typedef struct packed {
    logic           found;
    logic [PIW-1:0] idx;
  } rr_pick_t;

  // First set bit of req_mask at or after (last+1) mod nreq, wrapping once.
  function automatic rr_pick_t rr_pick(input logic [MAX_NREQ-1:0] req_mask,
                                       input int unsigned         last,
                                       input int unsigned         nreq);
    rr_pick_t    r;
    int unsigned cand;
    r = '0;
    for (int unsigned k = 1; k <= MAX_NREQ; k++) begin
      cand = (last + k) % nreq;
      if (k <= nreq && !r.found && req_mask[cand[PIW-1:0]]) begin
        r.found = 1'b1;
        r.idx   = cand[PIW-1:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/valid_rr_arbiter_fifo.sv
// Per-requester FIFO that absorbs words from a producer that cannot stall,
// dropping (and counting, saturating) words that find it full.
module rr_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 2,
  parameter int CW    = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          empty,
  output logic          can_push,
  output logic [CW-1:0] drop_cnt
);

  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);

  logic [DW-1:0]   r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CNTW-1:0] r_count;
  logic [CW-1:0]   r_drop_cnt;
  logic            w_write;
  logic            w_drop;

  // A pop in the same cycle frees the slot the incoming word needs.
  assign can_push = (r_count < CNTW'(DEPTH)) || pop;
  assign w_write  = push && can_push;
  assign w_drop   = push && !can_push;
  assign empty    = (r_count == '0);
  assign dout     = r_mem[r_rd_ptr];
  assign drop_cnt = r_drop_cnt;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // NOTE: storage has no reset; only pointers and count define validity, so
  // clearing the array would cost reset routing for no functional gain.
  always_ff @(posedge clk) begin
    if (w_write) r_mem[r_wr_ptr] <= din;
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_write) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (pop)     r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_write, pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_drop && r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/valid_rr_arbiter.sv
// Merges NREQ valid-only producers onto one valid/ready consumer through
// per-requester FIFOs and a rotating-priority registered output stage.
module valid_rr_arbiter
  import valid_rr_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int DW    = DW_DEF,
  parameter int DEPTH = 2,
  parameter int CW    = 16,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    in_valid,
  input  logic [NREQ*DW-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DW-1:0]      out_data,
  output logic [IW-1:0]      out_id,
  output logic [NREQ*CW-1:0] drop_cnt,
  output logic               busy
);

  logic [NREQ-1:0]     w_empty;
  logic [NREQ-1:0]     w_can_push;
  logic [NREQ-1:0]     w_pop;
  logic [DW-1:0]       w_fifo_dout [NREQ];
  logic [MAX_NREQ-1:0] w_req_mask;
  rr_pick_t            w_pick;
  logic [IW-1:0]       w_pick_id;
  logic [DW-1:0]       w_win_data;
  logic                w_load;

  logic                r_out_valid;
  logic [DW-1:0]       r_out_data;
  logic [IW-1:0]       r_out_id;
  logic [IW-1:0]       r_last;

  for (genvar g = 0; g < NREQ; g++) begin : g_req
    rr_fifo #(.DW(DW), .DEPTH(DEPTH), .CW(CW)) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (in_valid[g]),
      .pop      (w_pop[g]),
      .din      (in_data[g*DW +: DW]),
      .dout     (w_fifo_dout[g]),
      .empty    (w_empty[g]),
      .can_push (w_can_push[g]),
      .drop_cnt (drop_cnt[g*CW +: CW])
    );

    a_empty_has_space: assert property (@(posedge clk) disable iff (reset)
      w_empty[g] |-> w_can_push[g]);
  end

  // out_ready reaches only the load/pop enables, never the output register's
  // current contents.
  assign w_load = !r_out_valid || out_ready;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_req_mask             = '0;
    w_req_mask[NREQ-1:0]   = ~w_empty;
    w_pick                 = rr_pick(w_req_mask, 32'(r_last), NREQ);
    w_pick_id              = w_pick.idx[IW-1:0];
    w_win_data             = '0;
    w_pop                  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_pick_id == IW'(i)) begin
        w_win_data = w_fifo_dout[i];
        w_pop[i]   = w_load && w_pick.found;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_id    <= '0;
      r_last      <= IW'(NREQ - 1);
    end else if (w_load) begin
      if (w_pick.found) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_win_data;
        r_out_id    <= w_pick_id;
        r_last      <= w_pick_id;
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_id    = r_out_id;
  // Decoded purely from registered state, so no path from in_valid.
  assign busy      = r_out_valid || !(&w_empty);

endmodule

// File: tb/tb_valid_rr_arbiter.sv
// Self-checking bench for valid_rr_arbiter: directed scenarios plus random
// traffic compared against a queue-based reference model.
module tb_valid_rr_arbiter;

  localparam int NREQ  = 3;
  localparam int DW    = 32;
  localparam int DEPTH = 2;
  localparam int CW    = 16;
  localparam int IW    = $clog2(NREQ);

  logic               clk = 1'b0;
  logic               reset;
  logic [NREQ-1:0]    in_valid;
  logic [NREQ*DW-1:0] in_data;
  logic               out_valid;
  logic               out_ready;
  logic [DW-1:0]      out_data;
  logic [IW-1:0]      out_id;
  logic [NREQ*CW-1:0] drop_cnt;
  logic               busy;

  int n_tests = 0;
  int n_fail  = 0;

  valid_rr_arbiter #(.NREQ(NREQ), .DW(DW), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id),
    .drop_cnt  (drop_cnt),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference model: one queue per requester plus the output holding slot.
  logic [DW-1:0] mq [NREQ][$];
  logic [DW-1:0] m_acc0 [$];
  logic [CW-1:0] m_drop [NREQ];
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic [IW-1:0] m_id;
  int            m_last;

  task automatic model_step();
    bit found;
    int w;
    if (reset) begin
      for (int i = 0; i < NREQ; i++) begin
        mq[i].delete();
        m_drop[i] = '0;
      end
      m_valid = 1'b0;
      m_data  = '0;
      m_id    = '0;
      m_last  = NREQ - 1;
    end else begin
      if (!m_valid || out_ready) begin
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
          w = (m_last + k) % NREQ;
          if (!found && mq[w].size() > 0) begin
            found  = 1'b1;
            m_data = mq[w].pop_front();
            m_id   = IW'(w);
            m_last = w;
          end
        end
        m_valid = found;
      end
      for (int i = 0; i < NREQ; i++) begin
        if (in_valid[i]) begin
          if (mq[i].size() < DEPTH) begin
            mq[i].push_back(in_data[i*DW +: DW]);
            if (i == 0) m_acc0.push_back(in_data[i*DW +: DW]);
          end else if (m_drop[i] != '1) begin
            m_drop[i] = m_drop[i] + 1'b1;
          end
        end
      end
    end
  endtask

  // Inputs change only at negedge; outputs are inspected at negedge.
  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = 3'b111;
    in_data   = {32'hC, 32'hB, 32'hA};
    out_ready = 1'b1;
    repeat (3) step();
    n_tests++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_id !== '0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got v=%b d=%h id=%0d busy=%b, want all 0",
               out_valid, out_data, out_id, busy);
    end
    n_tests++;
    if (drop_cnt !== '0) begin
      n_fail++;
      $display("FAIL reset_drop: got %h want 0", drop_cnt);
    end
    reset   = 1'b0;
    in_data = {32'h33, 32'h22, 32'h11};
    step();
    in_valid = '0;
    step();
    n_tests++;
    if (out_valid !== 1'b1 || out_id !== 2'd0 || out_data !== 32'h11) begin
      n_fail++;
      $display("FAIL reset_first_grant: got v=%b id=%0d d=%h want v=1 id=0 d=11",
               out_valid, out_id, out_data);
    end
    repeat (3) step();
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_drain_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_latency();
    do_reset();
    out_ready = 1'b1;
    in_valid  = 3'b010;
    in_data   = '0;
    in_data[1*DW +: DW] = 32'h0000_002A;
    step();
    in_valid = '0;
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_no_bypass: out_valid got %b want 0 at c+1", out_valid);
    end
    step();
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== 32'h2A || out_id !== 2'd1) begin
      n_fail++;
      $display("FAIL latency_c2: got v=%b d=%h id=%0d want v=1 d=2a id=1",
               out_valid, out_data, out_id);
    end
    step();
    n_tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_idle: got v=%b busy=%b want 0 0", out_valid, busy);
    end
  endtask

  task automatic test_rotation();
    do_reset();
    out_ready = 1'b1;
    for (int rep = 0; rep < 2; rep++) begin
      in_valid = 3'b111;
      in_data  = {32'h30, 32'h20, 32'h10};
      step();
      in_valid = '0;
      for (int k = 0; k < NREQ; k++) begin
        step();
        n_tests++;
        if (out_valid !== 1'b1 || out_id !== IW'(k) || out_data !== 32'((k + 1) * 16)) begin
          n_fail++;
          $display("FAIL rotation_r%0d_k%0d: got v=%b id=%0d d=%h want v=1 id=%0d d=%h",
                   rep, k, out_valid, out_id, out_data, k, (k + 1) * 16);
        end
      end
      step();
    end
  endtask

  task automatic test_overflow();
    do_reset();
    out_ready = 1'b0;
    in_data   = '0;
    for (int w = 0; w < 4; w++) begin
      in_valid = 3'b100;
      in_data[2*DW +: DW] = 32'h100 + 32'(w);
      step();
    end
    in_valid = '0;
    n_tests++;
    if (drop_cnt[2*CW +: CW] !== 16'd1 || drop_cnt[0 +: 2*CW] !== '0) begin
      n_fail++;
      $display("FAIL overflow_drop: got %h want drop[2]=1 others 0", drop_cnt);
    end
    out_ready = 1'b1;
    for (int w = 0; w < 3; w++) begin
      n_tests++;
      if (out_valid !== 1'b1 || out_data !== 32'h100 + 32'(w) || out_id !== 2'd2) begin
        n_fail++;
        $display("FAIL overflow_word%0d: got v=%b d=%h id=%0d want v=1 d=%h id=2",
                 w, out_valid, out_data, out_id, 32'h100 + 32'(w));
      end
      step();
    end
    n_tests++;
    if (out_valid !== 1'b0 || drop_cnt[2*CW +: CW] !== 16'd1) begin
      n_fail++;
      $display("FAIL overflow_end: got v=%b drop2=%0d want v=0 drop2=1",
               out_valid, drop_cnt[2*CW +: CW]);
    end
  endtask

  task automatic test_backpressure();
    logic [4:0]    pat = 5'b10100;
    logic [DW-1:0] got [$];
    logic          pv, pr;
    logic [DW-1:0] pd;
    logic [IW-1:0] pid;
    int            stab_err = 0;
    do_reset();
    m_acc0.delete();
    in_data = '0;
    for (int c = 0; c < 40; c++) begin
      out_ready   = pat[c % 5];
      in_valid    = (c % 3 == 0) ? 3'b001 : 3'b000;
      in_data[0 +: DW] = 32'h200 + 32'(c);
      if (out_valid && out_ready) got.push_back(out_data);
      pv = out_valid; pr = out_ready; pd = out_data; pid = out_id;
      step();
      if (pv && !pr && (out_valid !== 1'b1 || out_data !== pd || out_id !== pid)) stab_err++;
    end
    in_valid  = '0;
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (out_valid) got.push_back(out_data);
      step();
    end
    n_tests++;
    if (stab_err != 0) begin
      n_fail++;
      $display("FAIL bp_stability: %0d unstable stalled cycles, want 0", stab_err);
    end
    n_tests++;
    if (got.size() != m_acc0.size() || got != m_acc0) begin
      n_fail++;
      $display("FAIL bp_stream: got %0d words want %0d (order/content compared)",
               got.size(), m_acc0.size());
    end
    n_tests++;
    if (drop_cnt[0 +: CW] !== m_drop[0]) begin
      n_fail++;
      $display("FAIL bp_drop: got %0d want %0d", drop_cnt[0 +: CW], m_drop[0]);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b0;
    in_valid  = 3'b111;
    in_data   = {32'hF3, 32'hF2, 32'hF1};
    repeat (3) step();
    n_tests++;
    if (out_valid !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_prefill: got v=%b busy=%b want 1 1", out_valid, busy);
    end
    reset = 1'b1;
    step();
    n_tests++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_id !== '0 || busy !== 1'b0 ||
        drop_cnt !== '0) begin
      n_fail++;
      $display("FAIL midrst_clear: got v=%b d=%h id=%0d busy=%b drop=%h want all 0",
               out_valid, out_data, out_id, busy, drop_cnt);
    end
    reset     = 1'b0;
    in_valid  = '0;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      n_tests++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL midrst_stale%0d: out_valid got %b want 0 (d=%h)", c, out_valid, out_data);
      end
    end
  endtask

  task automatic test_random();
    int thr;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      thr       = (c / 500) % 2 == 0 ? 85 : 25;
      reset     = ($urandom_range(299) == 0);
      in_valid  = NREQ'($urandom);
      in_data   = {$urandom, $urandom, $urandom};
      out_ready = ($urandom_range(99) < thr);
      step();
      n_tests++;
      if (out_valid !== m_valid || out_data !== m_data || out_id !== m_id) begin
        n_fail++;
        $display("FAIL rand_out c=%0d: got v=%b d=%h id=%0d want v=%b d=%h id=%0d",
                 c, out_valid, out_data, out_id, m_valid, m_data, m_id);
      end
      n_tests++;
      if (busy !== (m_valid || mq[0].size() > 0 || mq[1].size() > 0 || mq[2].size() > 0)) begin
        n_fail++;
        $display("FAIL rand_busy c=%0d: got %b", c, busy);
      end
      for (int i = 0; i < NREQ; i++) begin
        n_tests++;
        if (drop_cnt[i*CW +: CW] !== m_drop[i]) begin
          n_fail++;
          $display("FAIL rand_drop%0d c=%0d: got %0d want %0d",
                   i, c, drop_cnt[i*CW +: CW], m_drop[i]);
        end
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    in_valid  = '0;
    in_data   = '0;
    out_ready = 1'b1;
    @(negedge clk);
    test_reset();
    test_latency();
    test_rotation();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/valid_rr_arbiter.md
# valid_rr_arbiter

Round-robin arbiter that merges several valid-only producer channels onto one shared consumer channel with a valid/ready handshake. Each requester has a small FIFO, because producers in the simlib examples cannot be stalled. Overflow drops words and counts them. The block sits between multi-output sample modules (32-bit valid/data pairs, no backpressure) and a single downstream consumer or shared sink.

## Interface
- NREQ, 3: number of requester channels; must be at least 2.
- DW, 32: data width.
- DEPTH, 2: per-requester FIFO depth; must be at least 1.
- CW, 16: width of each drop counter.
- IW, $clog2(NREQ): width of the requester id (derived, not overridable).

Ports:
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high; sampled on posedge clk.
- in_valid  in  NREQ  bit i: requester i presents a word this cycle.
- in_data  in  NREQ*DW  slice [i*DW +: DW] is the word for requester i.
- out_valid  out  1  output register holds a word.
- out_ready  in  1  consumer accepts the word this cycle.
- out_data  out  DW  granted word.
- out_id  out  IW  index of the requester that supplied out_data.
- drop_cnt  out  NREQ*CW  slice [i*CW +: CW] counts words dropped for requester i.
- busy  out  1  high while any FIFO is non-empty or out_valid is high.

## Operation
- **Push.** Requester i pushes in_data[i] into FIFO i when in_valid[i] is high in a cycle where FIFO i has space: count < DEPTH, or a pop of FIFO i occurs in the same cycle.
- **Drop.** If in_valid[i] is high and FIFO i has no space, the word is discarded and drop_cnt[i] increments.
  - drop_cnt saturates at 2^CW-1 and never wraps.
- **Output register load.** The register loads when it is empty or when it is being drained (out_valid && out_ready) in that cycle.
- **Grant.** Among non-empty FIFOs, the winner is the first one found scanning (last+1) mod NREQ upward with wrap.
  - On load: pop the winner, and set out_data = head, out_id = winner, out_valid = 1, last = winner.
- **Idle.** If there is no candidate and the register drains, out_valid goes to 0 the next cycle.
- **Stability.** While out_valid && !out_ready, out_data and out_id hold stable and no FIFO pops.
- **Pointer update.** last updates only on a grant; an idle cycle does not advance the pointer.
- **Ordering.** Per-requester word order is preserved. There is no ordering guarantee across requesters.
- **Reset values.** out_valid=0, out_data=0, out_id=0, drop_cnt all 0, busy=0, all FIFOs empty, last=NREQ-1 (so requester 0 wins first).
- **Reset mid-operation.** Buffered and in-flight words are discarded silently and are not counted as drops.
- **In-range inputs.** No arithmetic on data. FIFO pointers wrap modulo DEPTH, and count is held in $clog2(DEPTH+1) bits.

## Timing
- **Latency.** A word with in_valid[i] high in cycle c appears on out_valid no earlier than cycle c+2 (FIFO write, then output register load). There is no bypass path.
- **Throughput.** One word per cycle while out_ready stays high and some FIFO is non-empty.
- **Full FIFO with simultaneous pop and push.** The push is accepted and not dropped.
- **Simultaneous pushes on all requesters.** All are accepted if space exists; the grant order then follows the rotating priority.
- **busy.** A registered function of the state after the edge, with no combinational path from in_valid.
- **out_ready.** May toggle arbitrarily. It combinationally affects only the pop and load enables, never out_valid or out_data within the same cycle.

## Structure
- **Shared package (valid_rr_pkg).** Holds DW default, id type logic [IW-1:0], and a function rr_pick(req_mask, last) returning the winner index and a found flag.
- **Sub-module rr_fifo.** Instantiated NREQ times; each instance is a DEPTH×DW FIFO plus its own saturating drop counter.
  - Ports: push, pop, din, dout, empty, can_push, drop_cnt.
- **Top level.** Contains the arbiter pointer, the output register, and busy.

## Test plan
- **Reset values.** Hold reset 3 cycles while driving in_valid=3'b111 -> all outputs 0, drop_cnt 0; first grant after release is id 0.
- **Single requester latency.** Drive in_valid[1] for one cycle with 32'h0000_002A, out_ready=1 -> cycle c+2 shows out_valid=1, out_data=32'h2A, out_id=1; the following cycle shows out_valid=0 and busy=0.
- **Rotating priority.** All three requesters push 32'h10, 32'h20, 32'h30 in the same cycle, out_ready=1 -> outputs in order id 0, 1, 2 on consecutive cycles. A repeat push yields order 0, 1, 2 again (last=2 wraps).
- **Overflow and drop count.** Hold out_ready=0 with DEPTH=2 and push 4 words on requester 2 -> drop_cnt[2]=1 (output register holds 1, FIFO holds 2). Releasing out_ready delivers the first 3 words in order.
- **Backpressure stability.** Toggle out_ready with pattern 0,0,1,0,1 while streaming -> out_data and out_id stay unchanged whenever out_valid && !out_ready, and no word is lost or duplicated.
- **Reset mid-operation.** Assert reset while FIFOs are full and out_valid=1 -> the next cycle shows everything cleared, drop counters 0, and no stale word emitted afterwards.
